msf_input_conditioner: RTL and testbench

MSF_INPUT_CONDITIONER -- requirements
Module: msf_input_conditioner

---
 rtl/msf_pkg.sv | 23 ++
 rtl/msf_input_conditioner_glitch_filter.sv | 73 +++++++
 rtl/msf_input_conditioner.sv | 91 +++++++++
 tb/tb_msf_input_conditioner.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/msf_pkg.sv
// Shared constants for the MSF receiver front end: default clock rate and
// the acceptance window applied to the measured second period.
package msf_pkg;

  localparam int MSF_CLK_FREQ = 12500;
  localparam int WIN_LO_NUM   = 9;
  localparam int WIN_HI_NUM   = 11;
  localparam int WIN_DEN      = 10;

  typedef struct packed {
    logic rise;
    logic fall;
  } edge_pulse_t;

  function automatic int win_min(input int clk_freq);
    return clk_freq * WIN_LO_NUM / WIN_DEN;
  endfunction

  function automatic int win_max(input int clk_freq);
    return clk_freq * WIN_HI_NUM / WIN_DEN;
  endfunction

endpackage

// File: rtl/msf_input_conditioner_glitch_filter.sv
// Synchronizer, saturating integrator with hysteresis, and registered
// edge pulses for the raw MSF carrier-off signal.
module glitch_filter
  import msf_pkg::*;
#(
  parameter int FILTER_LEN = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic data_i,
  input  logic invert_i,
  output logic data_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int IW = $clog2(FILTER_LEN + 1);
  localparam logic [IW-1:0] INT_MAX = IW'(FILTER_LEN);

  logic          sync1;
  logic          sync2;
  logic          x;
  logic [IW-1:0] integ;
  logic [IW-1:0] integ_nxt;
  logic          data_nxt;
  edge_pulse_t   pulse_nxt;

  assign x = sync2 ^ invert_i;

  always_comb begin
    integ_nxt = integ;
    if (x && (integ != INT_MAX)) begin
      integ_nxt = integ + IW'(1);
    end else if (!x && (integ != '0)) begin
      integ_nxt = integ - IW'(1);
    end else begin
      integ_nxt = integ;
    end
  end

  // Output only moves at the rails, so short excursions never reach data_o.
  always_comb begin
    data_nxt = data_o;
    if (integ_nxt == INT_MAX) begin
      data_nxt = 1'b1;
    end else if (integ_nxt == '0) begin
      data_nxt = 1'b0;
    end else begin
      data_nxt = data_o;
    end
    pulse_nxt.rise = data_nxt & ~data_o;
    pulse_nxt.fall = ~data_nxt & data_o;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      integ  <= '0;
      data_o <= 1'b0;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
    end else begin
      sync1  <= data_i;
      sync2  <= sync1;
      integ  <= integ_nxt;
      data_o <= data_nxt;
      rise_o <= pulse_nxt.rise;
      fall_o <= pulse_nxt.fall;
    end
  end

endmodule

// File: rtl/msf_input_conditioner.sv
// MSF input conditioner: glitch-filtered carrier level plus a lock flag
// raised once the start-of-second cadence has been stable for a while.
module msf_input_conditioner
  import msf_pkg::*;
#(
  parameter int CLK_FREQ   = MSF_CLK_FREQ,
  parameter int FILTER_LEN = 16,
  parameter int LOCK_COUNT = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic data_i,
  input  logic invert_i,
  output logic data_o,
  output logic rise_o,
  output logic fall_o,
  output logic lock_o
);

  localparam int MAX_P = win_max(CLK_FREQ);
  localparam int MIN_P = win_min(CLK_FREQ);
  localparam int PW    = $clog2(MAX_P + 2);
  localparam int GW    = $clog2(LOCK_COUNT + 1);

  localparam logic [PW-1:0] P_MIN  = PW'(MIN_P);
  localparam logic [PW-1:0] P_MAX  = PW'(MAX_P);
  localparam logic [PW-1:0] P_SAT  = PW'(MAX_P + 1);
  localparam logic [GW-1:0] G_LOCK = GW'(LOCK_COUNT);

  logic [PW-1:0] period;
  logic [PW-1:0] period_nxt;
  logic [GW-1:0] good;
  logic [GW-1:0] good_nxt;
  logic          ref_seen;
  logic          ref_nxt;

  glitch_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .data_i   (data_i),
    .invert_i (invert_i),
    .data_o   (data_o),
    .rise_o   (rise_o),
    .fall_o   (fall_o)
  );

  // A rise is evaluated before the timeout, so a rise at exactly MAX_P counts as good.
  always_comb begin
    period_nxt = period;
    good_nxt   = good;
    ref_nxt    = ref_seen;
    if (rise_o) begin
      period_nxt = PW'(1);
      ref_nxt    = 1'b1;
      if (ref_seen) begin
        if ((period >= P_MIN) && (period <= P_MAX)) begin
          good_nxt = (good == G_LOCK) ? good : good + GW'(1);
        end else begin
          good_nxt = '0;
        end
      end else begin
        good_nxt = good;
      end
    end else if (period == P_MAX) begin
      period_nxt = P_SAT;
      good_nxt   = '0;
      ref_nxt    = 1'b0;
    end else if (period != P_SAT) begin
      period_nxt = period + PW'(1);
    end else begin
      period_nxt = period;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      period   <= '0;
      good     <= '0;
      ref_seen <= 1'b0;
      lock_o   <= 1'b0;
    end else begin
      period   <= period_nxt;
      good     <= good_nxt;
      ref_seen <= ref_nxt;
      lock_o   <= (good == G_LOCK);
    end
  end

endmodule

// File: tb/tb_msf_input_conditioner.sv
// Bench for msf_input_conditioner: directed and randomized pulse trains
// compared every cycle against an event-level reference model.
module tb_msf_input_conditioner;

  localparam int CF   = 200;
  localparam int FL   = 16;
  localparam int LC   = 3;
  localparam int MAXP = CF * 11 / 10;
  localparam int MINP = CF * 9 / 10;

  logic clk = 1'b0;
  logic rst;
  logic data;
  logic inv;
  logic data_o;
  logic rise_o;
  logic fall_o;
  logic lock_o;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: values after the most recent edge.
  int n = 0;
  int last_load = 0;
  int m_s1, m_s2, m_int, m_dat, m_rise, m_fall, m_lock, m_ref, m_good;

  msf_input_conditioner #(
    .CLK_FREQ   (CF),
    .FILTER_LEN (FL),
    .LOCK_COUNT (LC)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .data_i   (data),
    .invert_i (inv),
    .data_o   (data_o),
    .rise_o   (rise_o),
    .fall_o   (fall_o),
    .lock_o   (lock_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b at edge %0d", tag, obs, exp, n);
    end
  endtask

  // Advance the reference by one clock edge using the spec's rules.
  task automatic model_edge(input logic d, input logic iv, input logic r);
    int x;
    int ni;
    int nd;
    int meas;
    if (r) begin
      m_s1 = 0; m_s2 = 0; m_int = 0; m_dat = 0; m_rise = 0; m_fall = 0;
      m_lock = 0; m_ref = 0; m_good = 0; last_load = n;
    end else begin
      m_lock = (m_good == LC) ? 1 : 0;
      meas = n - last_load;
      if (m_rise != 0) begin
        if (m_ref != 0) begin
          if (meas >= MINP && meas <= MAXP) m_good = (m_good < LC) ? m_good + 1 : LC;
          else m_good = 0;
        end
        m_ref = 1;
        last_load = n;
      end else if (m_ref != 0 && meas == MAXP) begin
        m_ref = 0;
        m_good = 0;
      end
      x  = m_s2 ^ int'(iv);
      ni = (x != 0) ? ((m_int < FL) ? m_int + 1 : FL) : ((m_int > 0) ? m_int - 1 : 0);
      nd = (ni == FL) ? 1 : ((ni == 0) ? 0 : m_dat);
      m_rise = (nd == 1 && m_dat == 0) ? 1 : 0;
      m_fall = (nd == 0 && m_dat == 1) ? 1 : 0;
      m_dat  = nd;
      m_int  = ni;
      m_s2   = m_s1;
      m_s1   = int'(d);
    end
    n++;
  endtask

  task automatic cycle(input logic d, input logic iv, input logic r);
    data = d;
    inv  = iv;
    rst  = r;
    @(posedge clk);
    model_edge(d, iv, r);
    #1;
    chk("data_o", data_o, m_dat != 0);
    chk("rise_o", rise_o, m_rise != 0);
    chk("fall_o", fall_o, m_fall != 0);
    chk("lock_o", lock_o, m_lock != 0);
  endtask

  // One second: carrier off for h cycles, optional glitch of g cycles in the gap.
  task automatic second(input int p, input int h, input int g, input logic iv);
    repeat (h) cycle(1'b1 ^ iv, iv, 1'b0);
    repeat (25) cycle(1'b0 ^ iv, iv, 1'b0);
    repeat (g) cycle(1'b1 ^ iv, iv, 1'b0);
    repeat (p - h - 25 - g) cycle(1'b0 ^ iv, iv, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    data = 1'b0;
    inv = 1'b0;
    repeat (3) cycle(1'b0, 1'b0, 1'b1);
    chk("reset_data", data_o, 1'b0);
    chk("reset_lock", lock_o, 1'b0);

    // Rise latency from an empty integrator.
    repeat (20) cycle(1'b1, 1'b0, 1'b0);
    chk("sat_high", data_o, 1'b1);
    repeat (25) cycle(1'b0, 1'b0, 1'b0);
    chk("sat_low", data_o, 1'b0);

    // Glitch just below and at the filter length.
    repeat (15) cycle(1'b1, 1'b0, 1'b0);
    repeat (25) cycle(1'b0, 1'b0, 1'b0);
    chk("glitch15", data_o, 1'b0);
    repeat (16) cycle(1'b1, 1'b0, 1'b0);
    repeat (25) cycle(1'b0, 1'b0, 1'b0);

    // Acquire lock, then window boundaries.
    repeat (4) second(200, 60, 0, 1'b0);
    chk("lock_train", lock_o, 1'b1);
    second(220, 60, 0, 1'b0);
    second(221, 60, 0, 1'b0);
    second(200, 60, 0, 1'b0);
    chk("lock_timeout", lock_o, 1'b0);
    repeat (3) second(200, 60, 0, 1'b0);
    chk("relock_timeout", lock_o, 1'b1);
    second(179, 60, 0, 1'b0);
    second(200, 60, 0, 1'b0);
    chk("lock_short", lock_o, 1'b0);
    second(180, 60, 0, 1'b0);
    repeat (3) second(200, 60, 0, 1'b0);
    chk("relock_short", lock_o, 1'b1);

    // Randomized periods, pulse widths, glitches and polarity.
    for (int i = 0; i < 16; i++) begin
      int p;
      int h;
      int g;
      p = $urandom_range(235, 170);
      h = $urandom_range(p - 40, 25);
      g = $urandom_range(15, 0);
      second(p, h, g, logic'($urandom_range(1, 0) == 1 && i > 10));
    end

    // Polarity flip with data held is just another level change.
    repeat (40) cycle(1'b0, 1'b1, 1'b0);
    repeat (40) cycle(1'b0, 1'b0, 1'b0);

    // Reset mid-pulse discards history.
    repeat (2) second(200, 60, 0, 1'b0);
    repeat (30) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1);
    chk("midrst_data", data_o, 1'b0);
    chk("midrst_lock", lock_o, 1'b0);
    repeat (3) second(200, 60, 0, 1'b0);

    // Inverted input from reset.
    repeat (2) cycle(1'b0, 1'b1, 1'b1);
    repeat (25) cycle(1'b0, 1'b1, 1'b0);
    chk("invert_high", data_o, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
